usb_tx_packetizer: RTL and testbench
====================================

Name: usb_tx_packetizer

Overview:
Downstream consumer of the byte queue on the USB transmit path. On a start request it builds one USB data/handshake packet: PID byte, then `len` payload bytes popped from the queue, then CRC16 (data packets only).
Bytes go to the bit-level serializer over a valid/ready byte handshake. The block owns the queue read-enable and never pops more bytes than the request length.

Parameters:
max_len, 64, maximum payload bytes per packet (full-speed bulk max)
len_w, $clog2(max_len+1), width of the len port

Ports:
clk  in  1  single clock for the block
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse; sampled only in IDLE
pid  in  4  PID code; the sent byte is {~pid, pid}
len  in  len_w  payload byte count; values above max_len are treated as max_len
with_data  in  1  1 = data packet (payload + CRC); 0 = handshake (PID only)
fifo_data  in  8  queue read data, valid the cycle after fifo_rd
fifo_empty  in  1  queue empty flag
fifo_rd  out  1  queue pop strobe, one byte per pulse
tx_data  out  8  byte to serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts the byte when tx_valid && tx_ready
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; fifo_rd, tx_valid, busy and done = 0; tx_data = 0x00; CRC = 0xFFFF; counters cleared. A reset mid-packet aborts the packet immediately. Bytes already popped are discarded, and the upstream queue must be flushed separately.
- States: IDLE, PID, FETCH, WAIT_RD, DATA, CRC_LO, CRC_HI, DONE.
- IDLE: on start, latch pid, len (clamped) and with_data; CRC = 0xFFFF; go to PID. start while busy is ignored.
- PID: tx_data = {~pid, pid}, tx_valid = 1.
  - On accept, go to DONE if with_data = 0.
  - On accept with with_data = 1: go to CRC_LO if len = 0, otherwise go to FETCH.
- FETCH: if fifo_empty = 0, assert fifo_rd for exactly one cycle and go to WAIT_RD. If fifo_empty = 1, stall in FETCH with tx_valid = 0; there is no timeout and no underrun abort.
- WAIT_RD: capture fifo_data into the hold register and update the CRC with it; go to DATA.
- DATA: tx_data = hold, tx_valid = 1.
  - On accept, decrement remaining; if it is now 0 go to CRC_LO, else go to FETCH.
  - Throughput is at most one byte per 3 cycles, which is ample for the bit rate.
- CRC: CRC16-USB, reflected polynomial 0xA001, init 0xFFFF, bytes processed LSB first. Transmitted value = ~crc.
- CRC_LO sends (~crc)[7:0]; CRC_HI sends (~crc)[15:8]. Each advances on accept, CRC_HI to DONE.
- DONE: done = 1 for one cycle, busy = 0 on the next cycle, return to IDLE.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and tx_valid are held stable.
  - tx_valid never drops without an accept, except on rst.
  - fifo_rd is never asserted when fifo_empty = 1, nor outside FETCH.
- busy = 1 in every state except IDLE. done and start may not overlap, because start is ignored during DONE.

Decomposition:
- Shared package usb_pkg holds:
  - PID constants: DATA0 = 4'b0011, DATA1 = 4'b1011, ACK = 4'b0010, NAK = 4'b1010.
  - CRC16 polynomial 16'hA001, init 16'hFFFF, residual.
  - The state enum.
- Sub-module usb_crc16: combinational byte update, crc_next = f(crc, byte). It is reused later by the receive path.

Test Plan:
1. ACK handshake: start with pid = 2, with_data = 0 → exactly one byte 0xD2, then a done pulse; fifo_rd never asserted.
2. Empty DATA0: pid = 3, len = 0, with_data = 1 → bytes 0xC3, 0x00, 0x00; no fifo_rd.
3. CRC check: queue preloaded with ASCII "123456789", DATA1, len = 9 → bytes 0x4B, 0x31..0x39, then 0xC8, 0xB4; exactly 9 fifo_rd pulses.
4. Backpressure: repeat scenario 3 with tx_ready toggling randomly → same byte sequence; tx_data is stable whenever tx_valid && !tx_ready.
5. Underrun stall: DATA0, len = 4, queue empty after 2 bytes; refill 5 cycles later → tx_valid low during the gap; bytes and CRC are identical to the no-gap case.
6. Reset mid-packet: rst asserted during DATA of a len = 8 packet → the next cycle shows IDLE with all outputs 0. A following start with pid = 2 and with_data = 0 sends 0xD2 correctly. len = 200 with max_len = 64 pops exactly 64 bytes.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC16 constants and the transmit packetizer state encoding.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  // Register value left after running a good packet's own CRC bytes through the checker.
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_FETCH,
    ST_WAIT_RD,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } usb_tx_state_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational CRC16-USB update for one byte, processed LSB first (reflected form).
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] w_c;

  always_comb begin
    w_c = i_crc ^ {8'h00, i_byte};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC16_POLY) : (w_c >> 1);
    end
  end

  assign o_crc = w_c;

endmodule

// File: rtl/usb_tx_packetizer.sv
// Builds one USB packet (PID, optional payload popped from the byte queue, CRC16)
// and hands it to the serializer over a valid/ready byte handshake.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int max_len = 64,
  parameter int len_w   = $clog2(max_len + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       pid,
  input  logic [len_w-1:0] len,
  input  logic             with_data,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  usb_tx_state_e    r_state;
  logic [len_w-1:0] r_remaining;
  logic             r_with_data;
  logic [15:0]      r_crc;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  logic [15:0]      w_crc_next;
  logic             w_accept;
  logic             w_fifo_rd;
  logic [len_w-1:0] w_len_clamped;

  usb_crc16 u_crc16 (
    .i_crc  (r_crc),
    .i_byte (fifo_data),
    .o_crc  (w_crc_next)
  );

  assign w_accept      = r_tx_valid && tx_ready;
  assign w_len_clamped = (len > len_w'(max_len)) ? len_w'(max_len) : len;
  // Decoded from state so the pop can never outlive FETCH or race an empty queue.
  assign w_fifo_rd     = (r_state == ST_FETCH) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_with_data <= 1'b0;
      r_crc       <= CRC16_INIT;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining <= w_len_clamped;
            r_with_data <= with_data;
            r_crc       <= CRC16_INIT;
            r_tx_data   <= pid_byte(pid);
            r_tx_valid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_PID;
          end
        end
        ST_PID: begin
          if (w_accept) begin
            if (!r_with_data) begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end else if (r_remaining == '0) begin
              r_tx_data <= ~r_crc[7:0];
              r_state   <= ST_CRC_LO;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!fifo_empty) begin
            r_state <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          // Queue data is valid one cycle after the pop; fold it into the CRC here.
          r_crc      <= w_crc_next;
          r_tx_data  <= fifo_data;
          r_tx_valid <= 1'b1;
          r_state    <= ST_DATA;
        end
        ST_DATA: begin
          if (w_accept) begin
            r_remaining <= r_remaining - len_w'(1);
            if (r_remaining == len_w'(1)) begin
              r_tx_data <= ~r_crc[7:0];
              r_state   <= ST_CRC_LO;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_CRC_LO: begin
          if (w_accept) begin
            r_tx_data <= ~r_crc[15:8];
            r_state   <= ST_CRC_HI;
          end
        end
        ST_CRC_HI: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd  = w_fifo_rd;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Scoreboard bench for usb_tx_packetizer: expected bytes queued at start, popped on each accept.
module tb_usb_tx_packetizer;
  import usb_pkg::*;

  localparam int MAXL = 64;
  localparam int LW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    pid;
  logic [LW-1:0] len;
  logic          with_data;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  usb_tx_packetizer #(.max_len(MAXL), .len_w(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pid        (pid),
    .len        (len),
    .with_data  (with_data),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Queue model: data appears the cycle after a pop.
  logic [7:0] mem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_block = 1'b0;
  logic flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || fifo_block;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd && (wr_ptr != rd_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  logic [7:0] exp_q [$];
  logic [7:0] pl [$];
  int   acc_count = 0;
  int   rd_count = 0;
  logic bp_en = 1'b0;
  logic hold_ready = 1'b0;
  logic [7:0] last_b0 = 8'h00;
  logic [7:0] last_b1 = 8'h00;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic prst = 1'b1;
  logic [7:0] pd = 8'h00;

  // Monitor: drives tx_ready, checks handshake stability, pops the scoreboard on accept.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (hold_ready)   tx_ready = 1'b0;
      else if (bp_en)   tx_ready = 1'($urandom_range(0, 1));
      else              tx_ready = 1'b1;
      if (!rst && !prst && pv && !pr) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      if (!rst) begin
        if (fifo_rd) begin
          rd_count++;
          chk("rd_when_empty", fifo_empty, 0);
        end
        if (tx_valid && tx_ready) begin
          acc_count++;
          last_b1 = last_b0;
          last_b0 = tx_data;
          if (exp_q.size() == 0) chk("extra_byte", tx_valid, 0);
          else                   chk("byte", tx_data, exp_q.pop_front());
        end
      end
      pv   = tx_valid;
      pr   = tx_ready;
      pd   = tx_data;
      prst = rst;
    end
  end

  task automatic load_pl();
    @(negedge clk);
    foreach (pl[i]) push(pl[i]);
  endtask

  task automatic start_pkt(input logic [3:0] p, input int l, input logic wd);
    int          eff;
    logic [15:0] c;
    exp_q.push_back({~p, p});
    if (wd) begin
      eff = (l > MAXL) ? MAXL : l;
      c   = 16'hFFFF;
      for (int i = 0; i < eff; i++) begin
        exp_q.push_back(pl[i]);
        c = crc_model(c, pl[i]);
      end
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
    rd_count  = 0;
    acc_count = 0;
    @(negedge clk);
    start     = 1'b1;
    pid       = p;
    len       = LW'(l);
    with_data = wd;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("sb_drained", exp_q.size(), 0);
      @(negedge clk);
      #2;
      chk("busy_cleared", busy, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic wait_acc(input int n, input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (acc_count >= n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("acc_reached", hit, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, tx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, fifo_rd, 0);
    chk({tag, "_data"}, tx_data, 0);
  endtask

  initial begin
    bit got_valid;
    rst = 1'b1; start = 1'b0; pid = 4'h0; len = '0; with_data = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // ACK handshake
    pl.delete();
    start_pkt(PID_ACK, 0, 1'b0);
    wait_done(50);
    chk("ack_bytes", acc_count, 1);
    chk("ack_rd", rd_count, 0);
    chk("ack_byte_val", last_b0, 8'hD2);

    // Empty DATA0
    start_pkt(PID_DATA0, 0, 1'b1);
    wait_done(50);
    chk("empty_bytes", acc_count, 3);
    chk("empty_rd", rd_count, 0);

    // "123456789" in DATA1, CRC bytes checked against the published value
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    load_pl();
    start_pkt(PID_DATA1, 9, 1'b1);
    wait_done(200);
    chk("crc9_bytes", acc_count, 12);
    chk("crc9_rd", rd_count, 9);
    chk("crc9_lo", last_b1, 8'hC8);
    chk("crc9_hi", last_b0, 8'hB4);

    // Same packet under random backpressure
    load_pl();
    bp_en = 1'b1;
    start_pkt(PID_DATA1, 9, 1'b1);
    wait_done(600);
    bp_en = 1'b0;
    chk("bp_bytes", acc_count, 12);
    chk("bp_rd", rd_count, 9);
    chk("bp_crc_lo", last_b1, 8'hC8);
    chk("bp_crc_hi", last_b0, 8'hB4);

    // Underrun: only two bytes available, the rest arrive after a gap
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    push(pl[0]);
    push(pl[1]);
    start_pkt(PID_DATA0, 4, 1'b1);
    wait_acc(3, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("gap_valid", tx_valid, 0);
    end
    @(negedge clk);
    push(pl[2]);
    push(pl[3]);
    wait_done(100);
    chk("underrun_bytes", acc_count, 7);
    chk("underrun_rd", rd_count, 4);

    // Reset while stalled in DATA of an 8-byte packet
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom_range(0, 255)));
    load_pl();
    start_pkt(PID_DATA0, 8, 1'b1);
    wait_acc(2, 100);
    @(negedge clk);
    hold_ready = 1'b1;
    got_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (tx_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    chk("stall_in_data", got_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    hold_ready = 1'b0;
    #2;
    chk_idle("midreset");

    pl.delete();
    start_pkt(PID_ACK, 0, 1'b0);
    wait_done(50);
    chk("post_reset_bytes", acc_count, 1);
    chk("post_reset_byte", last_b0, 8'hD2);

    // Oversized length clamps to max_len
    pl.delete();
    for (int i = 0; i < 70; i++) pl.push_back(8'($urandom_range(0, 255)));
    load_pl();
    start_pkt(PID_DATA0, 200, 1'b1);
    wait_done(1000);
    chk("clamp_rd", rd_count, 64);
    chk("clamp_bytes", acc_count, 67);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
